// File: rtl/fmc_eeprom_pkg.sv
// Shared FMC EEPROM definitions: one-hot state encoding, widths and default
// timing parameters used by the write- and read-side sequencers.
package fmc_eeprom_pkg;

  localparam int unsigned S_IDLE     = 0;
  localparam int unsigned S_ISSUE    = 1;
  localparam int unsigned S_WAIT     = 2;
  localparam int unsigned S_EVAL     = 3;
  localparam int unsigned S_HOLD     = 4;
  localparam int unsigned S_RWAIT    = 5;
  localparam int unsigned S_FINISH   = 6;
  localparam int unsigned NUM_STATES = 7;

  typedef logic [NUM_STATES-1:0] state_t;

  localparam state_t ST_IDLE   = 7'b0000001;
  localparam state_t ST_ISSUE  = 7'b0000010;
  localparam state_t ST_WAIT   = 7'b0000100;
  localparam state_t ST_EVAL   = 7'b0001000;
  localparam state_t ST_HOLD   = 7'b0010000;
  localparam state_t ST_RWAIT  = 7'b0100000;
  localparam state_t ST_FINISH = 7'b1000000;

  // States during which the sequencer reports busy.
  localparam state_t BUSY_MASK = ST_ISSUE | ST_WAIT | ST_EVAL | ST_HOLD | ST_RWAIT;

  localparam int unsigned BUF_DEPTH = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned DAT_W     = 8;
  localparam int unsigned ADR_W     = 8;
  localparam int unsigned DEV_W     = 7;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned RETRY_W   = 8;
  localparam int unsigned WDOG_W    = 23;
  localparam int unsigned DLY_W     = 20;

  localparam int unsigned DEF_MAX_RETRY   = 3;
  localparam int unsigned DEF_RETRY_DELAY = 625000;
  localparam int unsigned DEF_HOLDOFF     = 8;
  localparam int unsigned DEF_TIMEOUT     = 6250000;

endpackage

// File: rtl/eeprom_wr_buffer.sv
// 16x8 burst data buffer: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module eeprom_wr_buffer
  import fmc_eeprom_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wa_i,
  input  logic [DAT_W-1:0] wd_i,
  input  logic [IDX_W-1:0] ra_i,
  output logic [DAT_W-1:0] rd_o
);

  logic [DAT_W-1:0] mem_q [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/eeprom_write_sequencer.sv
// Burst write controller in front of the I2C byte writer: issues one byte at a
// time, retries NACKs after a delay, enforces re-arm holdoff and a watchdog.
module eeprom_write_sequencer
  import fmc_eeprom_pkg::*;
#(
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
  parameter int unsigned RETRY_DELAY = DEF_RETRY_DELAY,
  parameter int unsigned HOLDOFF     = DEF_HOLDOFF,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               buf_wr,
  input  logic [IDX_W-1:0]   buf_idx,
  input  logic [DAT_W-1:0]   buf_dat,
  input  logic               go,
  input  logic               dev_ext,
  input  logic [DEV_W-1:0]   dev_adr,
  input  logic [ADR_W-1:0]   start_adr,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               seq_done,
  output logic               seq_fail,
  output logic [CNT_W-1:0]   bytes_ok,
  output logic [RETRY_W-1:0] retries,
  output logic               i2c_dev_ext,
  output logic [DEV_W-1:0]   i2c_dev_adr,
  output logic [ADR_W-1:0]   i2c_reg_adr,
  output logic [DAT_W-1:0]   i2c_reg_dat,
  output logic               i2c_start_write,
  input  logic               i2c_wr_done,
  input  logic               i2c_error
);

  localparam int unsigned        RWAIT_CYC   = (RETRY_DELAY > HOLDOFF) ? RETRY_DELAY : HOLDOFF;
  localparam logic [DLY_W-1:0]   HOLD_LD     = DLY_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [DLY_W-1:0]   RWAIT_LD    = DLY_W'((RWAIT_CYC > 0) ? RWAIT_CYC - 1 : 0);
  localparam logic [WDOG_W-1:0]  WDOG_LD     = WDOG_W'(TIMEOUT);
  localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);

  state_t               state_q, state_d;
  logic                 fin_fail_c;
  logic                 ext_q, ext_d;
  logic [DEV_W-1:0]     dev_q, dev_d;
  logic [ADR_W-1:0]     sadr_q, sadr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     ok_q, ok_d;
  logic [RETRY_W-1:0]   retries_q, retries_d;
  logic [RETRY_W-1:0]   rcnt_q, rcnt_d;
  logic                 err_q, err_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [ADR_W-1:0]     radr_q, radr_d;
  logic [DAT_W-1:0]     rdat_q, rdat_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [IDX_W-1:0]     rd_idx_c;
  logic [DAT_W-1:0]     buf_rd_c;

  // ISSUE is only entered from IDLE (byte 0) or HOLD/RWAIT (idx_q already final).
  assign rd_idx_c = state_q[S_IDLE] ? '0 : idx_q[IDX_W-1:0];

  eeprom_wr_buffer u_buf (
    .clk  (clk),
    .we_i (buf_wr & state_q[S_IDLE]),
    .wa_i (buf_idx),
    .wd_i (buf_dat),
    .ra_i (rd_idx_c),
    .rd_o (buf_rd_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fin_fail_c = 1'b0;
    case (1'b1)
      state_q[S_IDLE]: begin
        if (go) begin
          if (count == '0) begin
            state_d = ST_FINISH;
          end else if (count > CNT_W'(BUF_DEPTH)) begin
            state_d    = ST_FINISH;
            fin_fail_c = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      state_q[S_ISSUE]: state_d = ST_WAIT;
      state_q[S_WAIT]: begin
        if (i2c_wr_done) begin
          state_d = ST_EVAL;
        end else if (wdog_q == '0) begin
          state_d    = ST_FINISH;
          fin_fail_c = 1'b1;
        end
      end
      state_q[S_EVAL]: begin
        if (!err_q) begin
          state_d = (idx_q + CNT_W'(1) == cnt_q) ? ST_FINISH : ST_HOLD;
        end else if (rcnt_q < MAX_RETRY_V) begin
          state_d = ST_RWAIT;
        end else begin
          state_d    = ST_FINISH;
          fin_fail_c = 1'b1;
        end
      end
      state_q[S_HOLD], state_q[S_RWAIT]: begin
        if (dly_q == '0) state_d = ST_ISSUE;
      end
      state_q[S_FINISH]: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ext_d     = ext_q;
    dev_d     = dev_q;
    sadr_d    = sadr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ok_d      = ok_q;
    retries_d = retries_q;
    rcnt_d    = rcnt_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    dly_d     = dly_q;
    radr_d    = radr_q;
    rdat_d    = rdat_q;

    if (state_q[S_IDLE] && go) begin
      ext_d     = dev_ext;
      dev_d     = dev_adr;
      sadr_d    = start_adr;
      cnt_d     = count;
      idx_d     = '0;
      ok_d      = '0;
      retries_d = '0;
      rcnt_d    = '0;
    end
    if (state_q[S_ISSUE]) begin
      err_d  = 1'b0;
      wdog_d = WDOG_LD;
    end
    if (state_q[S_WAIT]) begin
      if (i2c_error) err_d = 1'b1;
      if (wdog_q != '0) wdog_d = wdog_q - WDOG_W'(1);
    end
    if (state_q[S_EVAL]) begin
      if (!err_q) begin
        ok_d   = ok_q + CNT_W'(1);
        idx_d  = idx_q + CNT_W'(1);
        rcnt_d = '0;
        dly_d  = HOLD_LD;
      end else if (rcnt_q < MAX_RETRY_V) begin
        rcnt_d = rcnt_q + RETRY_W'(1);
        if (retries_q != '1) retries_d = retries_q + RETRY_W'(1);
        dly_d  = RWAIT_LD;
      end
    end
    if ((state_q[S_HOLD] || state_q[S_RWAIT]) && dly_q != '0) begin
      dly_d = dly_q - DLY_W'(1);
    end
    // Byte-writer address/data only change when a new attempt is issued.
    if (state_d[S_ISSUE]) begin
      radr_d = state_q[S_IDLE] ? start_adr : sadr_q + ADR_W'(idx_q);
      rdat_d = buf_rd_c;
    end

    busy_d  = |(state_d & BUSY_MASK);
    start_d = state_d[S_ISSUE];
    done_d  = state_d[S_FINISH];
    fail_d  = fin_fail_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q     <= 1'b0;
      dev_q     <= '0;
      sadr_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      ok_q      <= '0;
      retries_q <= '0;
      rcnt_q    <= '0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
      dly_q     <= '0;
      radr_q    <= '0;
      rdat_q    <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      dev_q     <= dev_d;
      sadr_q    <= sadr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ok_q      <= ok_d;
      retries_q <= retries_d;
      rcnt_q    <= rcnt_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
      dly_q     <= dly_d;
      radr_q    <= radr_d;
      rdat_q    <= rdat_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign busy            = busy_q;
  assign seq_done        = done_q;
  assign seq_fail        = fail_q;
  assign bytes_ok        = ok_q;
  assign retries         = retries_q;
  assign i2c_dev_ext     = ext_q;
  assign i2c_dev_adr     = dev_q;
  assign i2c_reg_adr     = radr_q;
  assign i2c_reg_dat     = rdat_q;
  assign i2c_start_write = start_q;

endmodule

// File: tb/tb_eeprom_write_sequencer.sv
// Bench for eeprom_write_sequencer: byte-writer model, burst-level expected
// transaction list and per-cycle compare, plus literal expectations.
module tb_eeprom_write_sequencer;

  localparam int unsigned RD  = 20;
  localparam int unsigned HO  = 4;
  localparam int unsigned TO  = 200;
  localparam int unsigned MR  = 3;
  localparam int          LAT = 3;
  localparam int          RW  = (RD > HO) ? RD : HO;

  logic       clk = 1'b0;
  logic       reset;
  logic       buf_wr;
  logic [3:0] buf_idx;
  logic [7:0] buf_dat;
  logic       go;
  logic       dev_ext;
  logic [6:0] dev_adr;
  logic [7:0] start_adr;
  logic [4:0] count;
  logic       busy, seq_done, seq_fail;
  logic [4:0] bytes_ok;
  logic [7:0] retries;
  logic       i2c_dev_ext;
  logic [6:0] i2c_dev_adr;
  logic [7:0] i2c_reg_adr, i2c_reg_dat;
  logic       i2c_start_write;
  logic       i2c_wr_done, i2c_error;

  eeprom_write_sequencer #(
    .MAX_RETRY(MR), .RETRY_DELAY(RD), .HOLDOFF(HO), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .buf_wr(buf_wr), .buf_idx(buf_idx), .buf_dat(buf_dat),
    .go(go), .dev_ext(dev_ext), .dev_adr(dev_adr), .start_adr(start_adr), .count(count),
    .busy(busy), .seq_done(seq_done), .seq_fail(seq_fail), .bytes_ok(bytes_ok),
    .retries(retries), .i2c_dev_ext(i2c_dev_ext), .i2c_dev_adr(i2c_dev_adr),
    .i2c_reg_adr(i2c_reg_adr), .i2c_reg_dat(i2c_reg_dat),
    .i2c_start_write(i2c_start_write), .i2c_wr_done(i2c_wr_done), .i2c_error(i2c_error)
  );

  always #5 clk = ~clk;

  int total, bad, cyc;
  logic [7:0] mem [16];

  // burst-level expectation
  logic [7:0] exp_reg [64];
  logic [7:0] exp_dat [64];
  int exp_n, exp_rd, exp_ok, exp_retries;
  logic exp_fail;
  logic cur_ext;
  logic [6:0] cur_dev;

  // observations
  logic [7:0] log_reg [64];
  logic [7:0] log_dat [64];
  int start_cyc [64];
  int n_starts, done_cyc, go_cyc, last_done;
  bit done_seen, busy_seen, prev_start, outst, have_last;
  logic [7:0] snap_reg, snap_dat, last_reg;

  // byte-writer model
  int err_byte, err_times, resp_byte, errs_given, tmr;
  bit hang, pend, cur_err;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic respond();
    i2c_error   = 1'b0;
    i2c_wr_done = 1'b0;
    if (reset || seq_done) begin
      pend = 0; resp_byte = 0; errs_given = 0;
    end else if (pend) begin
      tmr--;
      if (tmr == 1 && cur_err) i2c_error = 1'b1;
      if (tmr == 0) begin
        i2c_wr_done = 1'b1;
        pend = 0;
        if (!cur_err) resp_byte++;
      end
    end else if (i2c_start_write && !hang) begin
      pend    = 1;
      tmr     = LAT;
      cur_err = (resp_byte == err_byte) && (errs_given < err_times);
      if (cur_err) errs_given++;
    end
  endtask

  task automatic check();
    int req;
    if (reset) begin
      prev_start = 0; outst = 0;
      return;
    end
    if (i2c_start_write) begin
      chk("start_one_cycle", int'(prev_start), 0);
      chk("busy_on_start", int'(busy), 1);
      chk("dev_fields", int'({i2c_dev_ext, i2c_dev_adr}), int'({cur_ext, cur_dev}));
      if (exp_rd < exp_n) begin
        chk("reg_adr", int'(i2c_reg_adr), int'(exp_reg[exp_rd]));
        chk("reg_dat", int'(i2c_reg_dat), int'(exp_dat[exp_rd]));
      end else begin
        chk("start_count", exp_rd + 1, exp_n);
      end
      if (have_last) begin
        req = (i2c_reg_adr == last_reg) ? 2 + RW : 2 + HO;
        chk("issue_spacing", int'(cyc - last_done >= req), 1);
      end
      if (n_starts < 64) begin
        log_reg[n_starts] = i2c_reg_adr;
        log_dat[n_starts] = i2c_reg_dat;
        start_cyc[n_starts] = cyc;
      end
      n_starts++; exp_rd++;
      snap_reg = i2c_reg_adr; snap_dat = i2c_reg_dat; outst = 1;
    end
    prev_start = i2c_start_write;
    if (i2c_wr_done && outst) begin
      chk("held_until_done", int'({i2c_reg_adr, i2c_reg_dat}), int'({snap_reg, snap_dat}));
      last_done = cyc; last_reg = snap_reg; have_last = 1; outst = 0;
    end
    if (seq_done) begin
      done_seen = 1; done_cyc = cyc;
      chk("seq_fail", int'(seq_fail), int'(exp_fail));
      chk("bytes_ok", int'(bytes_ok), exp_ok);
      chk("retries", int'(retries), exp_retries);
      chk("busy_at_done", int'(busy), 0);
      chk("starts_at_done", exp_rd, exp_n);
    end else if (seq_fail) begin
      chk("fail_needs_done", int'(seq_done), 1);
    end
    if (busy) busy_seen = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    respond();
    check();
  endtask

  task automatic load(input int i, input logic [7:0] d);
    buf_wr = 1'b1; buf_idx = 4'(i); buf_dat = d;
    mem[i] = d;
    tick();
    buf_wr = 1'b0;
  endtask

  task automatic push(input logic [7:0] sa, input int b);
    exp_reg[exp_n] = 8'(sa + 8'(b));
    exp_dat[exp_n] = mem[b];
    exp_n++;
  endtask

  task automatic run_burst(input logic [7:0] sa, input int cnt, input int eb, input int et,
                           input bit hg, input bit inject, input int rst_after);
    int ne, ok, r;
    bit f;
    exp_n = 0; exp_rd = 0; n_starts = 0; have_last = 0; outst = 0;
    done_seen = 0; busy_seen = 0; ok = 0; r = 0; f = 0;
    if (cnt == 0) begin
    end else if (cnt > 16) begin
      f = 1;
    end else if (hg) begin
      push(sa, 0); f = 1;
    end else begin
      for (int b = 0; b < cnt; b++) begin
        ne = (b == eb) ? et : 0;
        if (ne > int'(MR)) begin
          for (int k = 0; k <= int'(MR); k++) push(sa, b);
          r += MR; f = 1;
          break;
        end
        for (int k = 0; k <= ne; k++) push(sa, b);
        r += ne; ok++;
      end
    end
    exp_fail = f; exp_ok = ok; exp_retries = r;
    err_byte = eb; err_times = et; hang = hg;

    dev_ext = cur_ext; dev_adr = cur_dev; start_adr = sa; count = 5'(cnt);
    go = 1'b1; go_cyc = cyc;
    tick();
    go = 1'b0;
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      if (inject && i == 6) begin
        go = 1'b1; start_adr = 8'h80; count = 5'd1;
        buf_wr = 1'b1; buf_idx = 4'd1; buf_dat = 8'h55;
      end
      tick();
      go = 1'b0; buf_wr = 1'b0;
      if (rst_after > 0 && n_starts == rst_after) begin
        tick();
        reset = 1'b1;
        #1;
        chk("rst_outputs_zero", int'(|{busy, seq_done, seq_fail, bytes_ok, retries, i2c_start_write,
                                        i2c_dev_ext, i2c_dev_adr, i2c_reg_adr, i2c_reg_dat}), 0);
        chk("rst_bytes_ok", int'(bytes_ok), 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        return;
      end
    end
    if (!done_seen) chk("burst_timeout", int'(done_seen), 1);
    tick();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; buf_wr = 1'b0; buf_idx = '0; buf_dat = '0; go = 1'b0;
    dev_ext = 1'b0; dev_adr = '0; start_adr = '0; count = '0;
    i2c_wr_done = 1'b0; i2c_error = 1'b0;
    err_byte = -1; err_times = 0; hang = 0; pend = 0; resp_byte = 0; errs_given = 0;
    cur_ext = 1'b1; cur_dev = 7'h50;
    tick(); tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(seq_done), 0);
    chk("reset_start", int'(i2c_start_write), 0);
    chk("reset_reg_adr", int'(i2c_reg_adr), 0);
    reset = 1'b0;
    tick();

    // 1: clean burst
    for (int i = 0; i < 4; i++) load(i, 8'(8'hA0 + i));
    run_burst(8'h10, 4, -1, 0, 0, 0, 0);
    chk("t1_first_start_latency", start_cyc[0] - go_cyc, 1);
    chk("t1_reg0", int'(log_reg[0]), 8'h10);
    chk("t1_dat0", int'(log_dat[0]), 8'hA0);
    chk("t1_reg3", int'(log_reg[3]), 8'h13);
    chk("t1_dat3", int'(log_dat[3]), 8'hA3);
    chk("t1_bytes_ok", int'(bytes_ok), 4);
    chk("t1_starts", n_starts, 4);

    // 2: address wrap
    cur_ext = 1'b0; cur_dev = 7'h51;
    run_burst(8'hFE, 3, -1, 0, 0, 0, 0);
    chk("t2_reg0", int'(log_reg[0]), 8'hFE);
    chk("t2_reg1", int'(log_reg[1]), 8'hFF);
    chk("t2_reg2", int'(log_reg[2]), 8'h00);
    chk("t2_dat2", int'(log_dat[2]), 8'hA2);

    // 3: retry then pass
    cur_ext = 1'b1; cur_dev = 7'h50;
    run_burst(8'h40, 4, 1, 2, 0, 0, 0);
    chk("t3_starts", n_starts, 6);
    chk("t3_retry_reg", int'(log_reg[2]), 8'h41);
    chk("t3_retry_reg2", int'(log_reg[3]), 8'h41);
    chk("t3_retries", int'(retries), 2);
    chk("t3_bytes_ok", int'(bytes_ok), 4);

    // 4a: retries exhausted on byte 2
    run_burst(8'h50, 4, 2, 100, 0, 0, 0);
    chk("t4_starts", n_starts, 6);
    chk("t4_bytes_ok", int'(bytes_ok), 2);
    chk("t4_retries", int'(retries), 3);
    // 4b: writer never answers
    run_burst(8'h60, 2, -1, 0, 1, 0, 0);
    chk("t4_wdog_window", int'(done_cyc - start_cyc[0] >= 200 && done_cyc - start_cyc[0] <= 204), 1);
    chk("t4_wdog_starts", n_starts, 1);

    // 5: boundaries
    run_burst(8'h00, 0, -1, 0, 0, 0, 0);
    chk("t5_cnt0_latency", done_cyc - go_cyc, 1);
    chk("t5_cnt0_starts", n_starts, 0);
    chk("t5_cnt0_busy", int'(busy_seen), 0);
    run_burst(8'h00, 17, -1, 0, 0, 0, 0);
    chk("t5_cnt17_latency", done_cyc - go_cyc, 1);
    chk("t5_cnt17_starts", n_starts, 0);
    chk("t5_cnt17_busy", int'(busy_seen), 0);
    run_burst(8'h20, 4, -1, 0, 0, 1, 0);
    chk("t5_inject_reg0", int'(log_reg[0]), 8'h20);
    chk("t5_inject_dat1", int'(log_dat[1]), 8'hA1);
    chk("t5_inject_starts", n_starts, 4);

    // 6: reset during WAIT of byte 1, then a normal single-byte burst
    run_burst(8'h70, 4, -1, 0, 0, 0, 2);
    run_burst(8'h90, 1, -1, 0, 0, 0, 0);
    chk("t6_reg0", int'(log_reg[0]), 8'h90);
    chk("t6_dat0", int'(log_dat[0]), 8'hA0);
    chk("t6_bytes_ok", int'(bytes_ok), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
